// File: rtl/lp_bridge_buffer.sv
// lp_bridge_buffer: captures per-head Q (West) and K (North) tiles into banks and feeds them slice by slice to multi_matmul_wrapper.
// Macro BRIDGE_BUF_PINGPONG_EN selects two ping-pong banks; undefined gives a single bank (no capture/matmul overlap).
module lp_bridge_buffer #(
  parameter int NUM_HEADS      = 1,
  parameter int TOTAL_INPUT_W  = 2,
  parameter int W_IN_WIDTH     = 512,
  parameter int N_IN_WIDTH     = 512,
  parameter int NUM_SLICES     = 4,
  parameter int W_SLICE_WIDTH  = W_IN_WIDTH / NUM_SLICES,
  parameter int N_MODULE_WIDTH = TOTAL_INPUT_W * N_IN_WIDTH / NUM_SLICES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_w,
  input  logic in_valid_n,
  input  logic [NUM_HEADS-1:0][TOTAL_INPUT_W-1:0][W_IN_WIDTH-1:0] w_din,
  input  logic [NUM_HEADS-1:0][TOTAL_INPUT_W-1:0][N_IN_WIDTH-1:0] n_din,
  output logic in_ready,
  input  logic acc_done_wrap,
  input  logic systolic_finish_wrap,
  output logic [NUM_HEADS-1:0][TOTAL_INPUT_W-1:0][W_SLICE_WIDTH-1:0] w_dout,
  output logic [NUM_HEADS-1:0][N_MODULE_WIDTH-1:0] n_dout,
  output logic internal_rst_n_ctrl,
  output logic internal_reset_acc_ctrl,
  output logic enable_matmul,
  output logic out_valid,
  output logic overflow
);

  localparam int KW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_SLICES - 1);
`ifdef BRIDGE_BUF_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif

  typedef logic [NUM_HEADS-1:0][TOTAL_INPUT_W-1:0][W_IN_WIDTH-1:0] w_tile_t;
  typedef logic [NUM_HEADS-1:0][TOTAL_INPUT_W-1:0][N_IN_WIDTH-1:0] n_tile_t;
  typedef logic [NUM_HEADS-1:0][TOTAL_INPUT_W-1:0][W_SLICE_WIDTH-1:0] w_slice_t;
  typedef logic [NUM_HEADS-1:0][N_MODULE_WIDTH-1:0] n_slice_t;
  typedef enum logic [2:0] {S_IDLE, S_MM_RST, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic wp_q, wp_d, rp_q, rp_d;
  logic [1:0] w_full_q, w_full_d, n_full_q, n_full_d;
  w_tile_t bank_w_q [2];
  n_tile_t bank_n_q [2];
  logic cap_w, cap_n;

  logic in_ready_q, in_ready_d;
  logic overflow_q, overflow_d;
  logic int_rst_n_q, int_rst_n_d;
  logic reset_acc_q, reset_acc_d;
  logic enable_q, enable_d;
  logic out_valid_q, out_valid_d;
  w_slice_t w_dout_q, w_dout_d, w_slice;
  n_slice_t n_dout_q, n_dout_d, n_slice;
  logic slice_en;

  // Bank bookkeeping: release of bank rp and capture into bank wp may land in the same cycle.
  always_comb begin
    cap_w    = in_valid_w && in_ready_q;
    cap_n    = in_valid_n && in_ready_q;
    w_full_d = w_full_q;
    n_full_d = n_full_q;
    if (state_q == S_DONE) begin
      w_full_d[rp_q] = 1'b0;
      n_full_d[rp_q] = 1'b0;
    end
    if (cap_w) w_full_d[wp_q] = 1'b1;
    if (cap_n) n_full_d[wp_q] = 1'b1;
    wp_d = wp_q;
    if (PINGPONG && (cap_w || cap_n) && w_full_d[wp_q] && n_full_d[wp_q]) wp_d = ~wp_q;
    rp_d = rp_q;
    if (PINGPONG && (state_q == S_DONE)) rp_d = ~rp_q;
    in_ready_d = !(w_full_d[wp_d] && n_full_d[wp_d]);
    overflow_d = overflow_q | ((in_valid_w | in_valid_n) & ~in_ready_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE:   if (w_full_q[rp_q] && n_full_q[rp_q]) state_d = S_MM_RST;
      S_MM_RST: begin
        k_d     = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (acc_done_wrap) begin
          if (k_q == K_LAST) state_d = systolic_finish_wrap ? S_DONE : S_DRAIN;
          else               k_d = k_q + 1'b1;
        end
      end
      S_DRAIN:  if (systolic_finish_wrap) state_d = S_DONE;
      S_DONE:   state_d = (w_full_d[rp_d] && n_full_d[rp_d]) ? S_MM_RST : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_HEADS; gi++) begin : g_head
    logic [TOTAL_INPUT_W*N_IN_WIDTH-1:0] n_flat;
    assign n_flat      = bank_n_q[rp_q][gi];
    assign n_slice[gi] = n_flat[int'(k_d)*N_MODULE_WIDTH +: N_MODULE_WIDTH];
    for (genvar gr = 0; gr < TOTAL_INPUT_W; gr++) begin : g_row
      assign w_slice[gi][gr] = bank_w_q[rp_q][gi][gr][int'(k_d)*W_SLICE_WIDTH +: W_SLICE_WIDTH];
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    slice_en    = (state_d == S_RUN) || (state_d == S_DRAIN);
    enable_d    = slice_en;
    int_rst_n_d = (state_d != S_MM_RST);
    reset_acc_d = (state_d == S_MM_RST);
    out_valid_d = (state_d == S_DONE);
    w_dout_d    = slice_en ? w_slice : '0;
    n_dout_d    = slice_en ? n_slice : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      w_full_q    <= '0;
      n_full_q    <= '0;
      bank_w_q    <= '{default: '0};
      bank_n_q    <= '{default: '0};
      in_ready_q  <= 1'b1;
      overflow_q  <= 1'b0;
      int_rst_n_q <= 1'b0;
      reset_acc_q <= 1'b0;
      enable_q    <= 1'b0;
      out_valid_q <= 1'b0;
      w_dout_q    <= '0;
      n_dout_q    <= '0;
    end else begin
      if (cap_w) bank_w_q[wp_q] <= w_din;
      if (cap_n) bank_n_q[wp_q] <= n_din;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      w_full_q    <= w_full_d;
      n_full_q    <= n_full_d;
      in_ready_q  <= in_ready_d;
      overflow_q  <= overflow_d;
      int_rst_n_q <= int_rst_n_d;
      reset_acc_q <= reset_acc_d;
      enable_q    <= enable_d;
      out_valid_q <= out_valid_d;
      w_dout_q    <= w_dout_d;
      n_dout_q    <= n_dout_d;
    end
  end

  assign in_ready                = in_ready_q;
  assign overflow                = overflow_q;
  assign internal_rst_n_ctrl     = int_rst_n_q;
  assign internal_reset_acc_ctrl = reset_acc_q;
  assign enable_matmul           = enable_q;
  assign out_valid               = out_valid_q;
  assign w_dout                  = w_dout_q;
  assign n_dout                  = n_dout_q;

endmodule

// File: tb/tb_lp_bridge_buffer.sv
// Directed bench for lp_bridge_buffer: 2 heads, 4 slices, byte-ramp tiles so every slice is a known byte pattern.
// Honours BRIDGE_BUF_PINGPONG_EN where single-bank and ping-pong behaviour differ.
module tb_lp_bridge_buffer;
  localparam int NH = 2;
  localparam int TW = 2;
  localparam int WW = 32;
  localparam int NW = 16;
  localparam int NS = 4;
  localparam int WS = WW / NS;
  localparam int NM = TW * NW / NS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid_w = 1'b0;
  logic in_valid_n = 1'b0;
  logic [NH-1:0][TW-1:0][WW-1:0] w_din = '0;
  logic [NH-1:0][TW-1:0][NW-1:0] n_din = '0;
  logic in_ready;
  logic acc_done_wrap = 1'b0;
  logic systolic_finish_wrap = 1'b0;
  logic [NH-1:0][TW-1:0][WS-1:0] w_dout;
  logic [NH-1:0][NM-1:0] n_dout;
  logic internal_rst_n_ctrl, internal_reset_acc_ctrl, enable_matmul, out_valid, overflow;

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  lp_bridge_buffer #(
    .NUM_HEADS(NH), .TOTAL_INPUT_W(TW), .W_IN_WIDTH(WW), .N_IN_WIDTH(NW), .NUM_SLICES(NS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_w(in_valid_w), .in_valid_n(in_valid_n),
    .w_din(w_din), .n_din(n_din), .in_ready(in_ready),
    .acc_done_wrap(acc_done_wrap), .systolic_finish_wrap(systolic_finish_wrap),
    .w_dout(w_dout), .n_dout(n_dout),
    .internal_rst_n_ctrl(internal_rst_n_ctrl), .internal_reset_acc_ctrl(internal_reset_acc_ctrl),
    .enable_matmul(enable_matmul), .out_valid(out_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Row r of head h in tile t holds bytes wb+0..wb+3 (byte 0 at LSB).
  task automatic load_w(input int t);
    for (int h = 0; h < NH; h++)
      for (int r = 0; r < TW; r++)
        for (int b = 0; b < 4; b++)
          w_din[h][r][b*8 +: 8] = 8'(t*32 + h*16 + r*4 + b);
    in_valid_w = 1'b1;
  endtask

  // North row r carries bytes nb+2r, nb+2r+1, so {row1,row0} is nb+0..nb+3 from the LSB.
  task automatic load_n(input int t);
    for (int h = 0; h < NH; h++)
      for (int r = 0; r < TW; r++)
        for (int b = 0; b < 2; b++)
          n_din[h][r][b*8 +: 8] = 8'(128 + t*32 + h*16 + 2*r + b);
    in_valid_n = 1'b1;
  endtask

  function automatic logic [63:0] exp_w(input int t, input int k);
    logic [63:0] v = '0;
    for (int h = 0; h < NH; h++)
      for (int r = 0; r < TW; r++)
        v[(h*TW + r)*8 +: 8] = 8'(t*32 + h*16 + r*4 + k);
    return v;
  endfunction

  function automatic logic [63:0] exp_n(input int t, input int k);
    logic [63:0] v = '0;
    for (int h = 0; h < NH; h++)
      v[h*8 +: 8] = 8'(128 + t*32 + h*16 + k);
    return v;
  endfunction

  task automatic chk_slice(input string tag, input int t, input int k);
    chk({tag, "_w"}, 64'(w_dout), exp_w(t, k));
    chk({tag, "_n"}, 64'(n_dout), exp_n(t, k));
  endtask

  task automatic pulse_acc();
    acc_done_wrap = 1'b1;
    tick();
    acc_done_wrap = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_int_rst_n", 64'(internal_rst_n_ctrl), 64'd0);
    chk("rst_enable", 64'(enable_matmul), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_w_dout", 64'(w_dout), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_int_rst_n", 64'(internal_rst_n_ctrl), 64'd1);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_overflow", 64'(overflow), 64'd0);

    // Tile 0: W at cycle 0, N at cycle 3
    load_w(0); tick(); in_valid_w = 1'b0;
    chk("t0_w_only_ready", 64'(in_ready), 64'd1);
    tick(); tick();
    load_n(0); tick(); in_valid_n = 1'b0;
`ifdef BRIDGE_BUF_PINGPONG_EN
    chk("t0_full_ready", 64'(in_ready), 64'd1);
`else
    chk("t0_full_ready", 64'(in_ready), 64'd0);
`endif
    chk("t0_still_idle", 64'(internal_reset_acc_ctrl), 64'd0);
    tick();
    chk("t0_mmrst_rstn", 64'(internal_rst_n_ctrl), 64'd0);
    chk("t0_mmrst_acc", 64'(internal_reset_acc_ctrl), 64'd1);
    chk("t0_mmrst_en", 64'(enable_matmul), 64'd0);
    tick();
    chk("t0_run_en", 64'(enable_matmul), 64'd1);
    chk("t0_run_rstn", 64'(internal_rst_n_ctrl), 64'd1);
    chk_slice("t0_s0", 0, 0);
    tick();
    chk_slice("t0_s0_hold", 0, 0);
    pulse_acc();
    chk_slice("t0_s1", 0, 1);

    // Second tile during RUN (ping-pong only), then a tile that must be dropped
`ifdef BRIDGE_BUF_PINGPONG_EN
    chk("t1_ready_in_run", 64'(in_ready), 64'd1);
    load_w(1); load_n(1); tick(); in_valid_w = 1'b0; in_valid_n = 1'b0;
    chk("both_full_ready", 64'(in_ready), 64'd0);
    chk_slice("t0_s1_after_cap", 0, 1);
`else
    chk("single_ready_in_run", 64'(in_ready), 64'd0);
`endif
    load_w(2); load_n(2); tick(); in_valid_w = 1'b0; in_valid_n = 1'b0;
    chk("overflow_set", 64'(overflow), 64'd1);
    pulse_acc();
    chk_slice("t0_s2", 0, 2);
    pulse_acc();
    chk_slice("t0_s3", 0, 3);
    pulse_acc();
    chk("t0_drain_en", 64'(enable_matmul), 64'd1);
    chk("t0_drain_ov", 64'(out_valid), 64'd0);
    chk_slice("t0_drain_hold", 0, 3);
    tick();
    chk("t0_drain_wait_ov", 64'(out_valid), 64'd0);
    systolic_finish_wrap = 1'b1; tick(); systolic_finish_wrap = 1'b0;
    chk("t0_done_ov", 64'(out_valid), 64'd1);
    chk("t0_done_en", 64'(enable_matmul), 64'd0);
    tick();
    chk("t0_ov_pulse", 64'(out_valid), 64'd0);
`ifdef BRIDGE_BUF_PINGPONG_EN
    chk("t1_mmrst_no_idle", 64'(internal_reset_acc_ctrl), 64'd1);
`else
    chk("t0_back_idle", 64'(internal_reset_acc_ctrl), 64'd0);
    chk("t0_ready_after_done", 64'(in_ready), 64'd1);
    load_w(1); load_n(1); tick(); in_valid_w = 1'b0; in_valid_n = 1'b0;
    tick();
    chk("t1_mmrst", 64'(internal_reset_acc_ctrl), 64'd1);
`endif

    // Tile 1 drains; last acc_done coincides with systolic_finish
    tick();
    chk_slice("t1_s0", 1, 0);
    for (int k = 1; k < NS; k++) begin
      pulse_acc();
      chk_slice($sformatf("t1_s%0d", k), 1, k);
    end
    acc_done_wrap = 1'b1; systolic_finish_wrap = 1'b1; tick();
    acc_done_wrap = 1'b0; systolic_finish_wrap = 1'b0;
    chk("t1_coinc_ov", 64'(out_valid), 64'd1);
    tick();
    chk("t1_ov_pulse", 64'(out_valid), 64'd0);
    chk("t1_idle_en", 64'(enable_matmul), 64'd0);
    chk("t1_idle_acc", 64'(internal_reset_acc_ctrl), 64'd0);
    chk("overflow_sticky", 64'(overflow), 64'd1);
    chk("t1_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset in RUN at slice 2
    load_w(3); load_n(3); tick(); in_valid_w = 1'b0; in_valid_n = 1'b0;
    tick(); tick();
    pulse_acc(); pulse_acc();
    chk_slice("t3_s2", 3, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_en", 64'(enable_matmul), 64'd0);
    chk("arst_int_rstn", 64'(internal_rst_n_ctrl), 64'd0);
    chk("arst_w_dout", 64'(w_dout), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("arst_rel_ready", 64'(in_ready), 64'd1);
    chk("arst_rel_rstn", 64'(internal_rst_n_ctrl), 64'd1);
    chk("arst_overflow_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("arst_no_ov_%0d", i), 64'(out_valid), 64'd0);
      chk($sformatf("arst_no_en_%0d", i), 64'(enable_matmul), 64'd0);
      tick();
    end

    // Fresh tile after reset runs from slice 0
    load_w(2); tick(); in_valid_w = 1'b0;
    load_n(2); tick(); in_valid_n = 1'b0;
    tick();
    chk("t2_mmrst", 64'(internal_reset_acc_ctrl), 64'd1);
    tick();
    chk_slice("t2_s0", 2, 0);
    for (int k = 1; k < NS; k++) begin
      pulse_acc();
      chk_slice($sformatf("t2_s%0d", k), 2, k);
    end
    pulse_acc();
    systolic_finish_wrap = 1'b1; tick(); systolic_finish_wrap = 1'b0;
    chk("t2_done_ov", 64'(out_valid), 64'd1);
    tick();
    chk("t2_ov_pulse", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/lp_bridge_buffer.md
# lp_bridge_buffer

Multi-head ping-pong bridge buffer between the linear-projection stage and the following Qn·KnT matmul. Per head, it captures one full West (Q) tile and one full North (K) tile from the projection outputs into one of two banks. It then serialises each tile into per-step slices for `multi_matmul_wrapper`, pacing on the matmul's `acc_done_wrap` and `systolic_finish_wrap`. The wrapper's reset, accumulator reset and enable are generated here, so the projection can fill one bank while the matmul drains the other.

## Interface
Parameters:
- NUM_HEADS, 1, number of independent head lanes (Q/K pairs), all stepped in lockstep
- TOTAL_INPUT_W, 2, rows per tile
- W_IN_WIDTH, 512, bits per West input row
- N_IN_WIDTH, 512, bits per North input row
- NUM_SLICES, 4, matmul steps per tile; must divide W_IN_WIDTH and TOTAL_INPUT_W*N_IN_WIDTH
- W_SLICE_WIDTH, W_IN_WIDTH/NUM_SLICES, derived
- N_MODULE_WIDTH, TOTAL_INPUT_W*N_IN_WIDTH/NUM_SLICES, derived

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid_w  in  1  West tile present on w_din
- in_valid_n  in  1  North tile present on n_din
- w_din  in  W_IN_WIDTH x [NUM_HEADS][TOTAL_INPUT_W]  Q tile rows
- n_din  in  N_IN_WIDTH x [NUM_HEADS][TOTAL_INPUT_W]  K tile rows
- in_ready  out  1  a write bank can accept a tile this cycle
- acc_done_wrap  in  1  matmul finished the current slice step
- systolic_finish_wrap  in  1  matmul array drained after the last step
- w_dout  out  W_SLICE_WIDTH x [NUM_HEADS][TOTAL_INPUT_W]  current West slice
- n_dout  out  N_MODULE_WIDTH x [NUM_HEADS]  current North slice
- internal_rst_n_ctrl  out  1  active-low reset to matmul
- internal_reset_acc_ctrl  out  1  accumulator clear to matmul
- enable_matmul  out  1  matmul enable
- out_valid  out  1  one-cycle pulse: matmul result for the tile is complete
- overflow  out  1  sticky: a tile arrived while in_ready was low

## Operation
- Banks: two (B0, B1). Each bank holds, per head, TOTAL_INPUT_W West rows and TOTAL_INPUT_W North rows, plus w_full and n_full flags. Write pointer wp and read pointer rp start at B0.
- Capture: in_valid_w && in_ready stores all of w_din into bank wp and sets w_full. The North side works the same way. W and N may arrive in any order or cycle. A repeat of an already-full side overwrites it. When both flags are set, the bank is full and wp toggles.
- in_ready = bank wp not full.
- Any valid while in_ready=0 is dropped and sets overflow. overflow clears only on reset.
- West slicing: slice k of row r is w_row[r][k*W_SLICE_WIDTH +: W_SLICE_WIDTH].
- North slicing: the North slice k is bits [k*N_MODULE_WIDTH +: N_MODULE_WIDTH] of the concatenation {row[TOTAL_INPUT_W-1],…,row[0]}, with row 0 at the LSB.
- Read FSM states:
  - IDLE: wait until bank rp is full, then go to MM_RST.
  - MM_RST: one cycle with internal_rst_n_ctrl=0 and internal_reset_acc_ctrl=1. k=0. Go to RUN.
  - RUN: enable_matmul=1 and slice k is presented. On acc_done_wrap, k increments; on acc_done_wrap with k=NUM_SLICES-1, go to DRAIN (slice held).
  - DRAIN: enable_matmul=1; on systolic_finish_wrap go to DONE.
  - DONE: out_valid=1 for one cycle. Clear bank rp's flags and toggle rp. Next state is MM_RST if the other bank is already full, else IDLE.
- Simultaneous events:
  - acc_done_wrap on the last slice together with systolic_finish_wrap goes directly to DONE.
  - acc_done_wrap and systolic_finish_wrap are ignored in IDLE and MM_RST.
  - A capture into bank wp in the same cycle bank rp is released in DONE is legal; both take effect.
- All heads share one FSM and one slice index.

## Timing
- Reset values:
  - internal_rst_n_ctrl=0 while rst_n is low, 1 from the first clock after release (except in MM_RST).
  - All other outputs are 0, except in_ready=1 after reset.
  - Banks, flags and pointers are cleared; FSM is in IDLE.
- All outputs are registered.
- Tile completing a bank at edge t, with FSM idle:
  - MM_RST is visible at t+1.
  - Slice 0 and enable_matmul are visible at t+2.
- A slice advance is visible on the edge after acc_done_wrap.
- out_valid appears the cycle after systolic_finish_wrap.
- Back-to-back tiles: MM_RST follows DONE immediately, with no IDLE cycle.
- Asynchronous reset mid-tile discards both banks; no out_valid is produced.

## Configuration
- BRIDGE_BUF_PINGPONG_EN defined: two banks, behaviour as above.
- BRIDGE_BUF_PINGPONG_EN undefined: a single bank; wp and rp are fixed at 0.
  - in_ready stays low from bank full until DONE.
  - No overlap of capture and matmul.
  - All other behaviour is identical.

## Test plan
- Test configuration: NUM_HEADS=2, NUM_SLICES=4. W tile at cycle 0, N tile at cycle 3 (known ramp data). Required response:
  - MM_RST at cycle 4.
  - Slices 0..3 are presented in order, each advancing one cycle after acc_done_wrap.
  - Slice contents match the bit-slice rules for both heads.
  - out_valid pulses once, one cycle after systolic_finish_wrap.
- Second tile (W and N together) captured while the first is in RUN: in_ready stays 1, and MM_RST follows DONE with no IDLE cycle. Without the macro, in_ready=0 during RUN.
- Third tile while both banks are full: in_ready=0, the tile is dropped, overflow=1 and stays 1. Data for the first two tiles is unaffected.
- acc_done_wrap on slice 3 coincident with systolic_finish_wrap: DONE on the next cycle, out_valid pulses exactly once.
- rst_n low during RUN at slice 2:
  - Immediately: enable_matmul=0, internal_rst_n_ctrl=0, w_dout=0.
  - After release: in_ready=1, no out_valid, and the next tile processes normally from slice 0.
